// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_pkg
// Brief    : Shared constants, counter sizing and shift direction for the
//            PISO serializer. Direction follows macro PISO_MSB_FIRST_EN.
// Revision : 1.0
// ============================================================================
package piso_pkg;

  localparam int DATA_WIDTH_DEF = 9;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } shift_dir_e;

`ifdef PISO_MSB_FIRST_EN
  localparam shift_dir_e SHIFT_DIR = MSB_FIRST;
`else
  localparam shift_dir_e SHIFT_DIR = LSB_FIRST;
`endif

  // Bits needed to hold a count of 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module   : piso_bit_cnt
// Brief    : Loadable, saturating down-counter of bits left to send; empty
//            flags a fully drained word.
// Revision : 1.0
// ============================================================================
module piso_bit_cnt #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  output logic [CW-1:0] cnt_o,
  output logic          empty_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule : piso_bit_cnt
`default_nettype wire

// File: rtl/piso_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_register
// Brief    : Parallel-in serial-out shift register, one bit per clock.
//            LSB-first by default; MSB-first when PISO_MSB_FIRST_EN is defined.
// Revision : 1.0
// ============================================================================
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:1] x,
  output logic [DATA_WIDTH-1:1] y,
  output logic                  z,
  output logic                  empty
);

  localparam int W  = DATA_WIDTH - 1;
  localparam int CW = cnt_width(W);

  logic [DATA_WIDTH-1:1] y_q;
  logic [DATA_WIDTH-1:1] y_d;
  logic [CW-1:0]         cnt;

  piso_bit_cnt #(
    .W  (W),
    .CW (CW)
  ) u_bit_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .cnt_o   (cnt),
    .empty_o (empty)
  );

  always_comb begin
    y_d = y_q;
    if (load) begin
      y_d = x;
    end else begin
`ifdef PISO_MSB_FIRST_EN
      y_d = {y_q[DATA_WIDTH-2:1], 1'b0};
`else
      y_d = {1'b0, y_q[DATA_WIDTH-1:2]};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

`ifdef PISO_MSB_FIRST_EN
  assign z = y_q[DATA_WIDTH-1];
`else
  assign z = y_q[1];
`endif

  // A drained word has shifted every loaded bit out, so nothing may remain.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt <= CW'(W));
      assert (!empty || (y_q == '0));
      assert (z == ((SHIFT_DIR == MSB_FIRST) ? y_q[DATA_WIDTH-1] : y_q[1]));
    end
  end

endmodule : piso_shift_register
`default_nettype wire

// File: tb/tb_piso_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_shift_register
// Brief    : Directed self-checking bench, DATA_WIDTH=9, LSB-first build.
// Revision : 1.0
// ============================================================================
module tb_piso_shift_register;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [8:1] x;
  logic [8:1] y;
  logic       z;
  logic       empty;

  int errors = 0;
  int checks = 0;

  piso_shift_register #(.DATA_WIDTH(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .x     (x),
    .y     (y),
    .z     (z),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [7:0] exp_y [8];
    logic [7:0] w;
    logic [15:0] stream;

    rst_n = 1'b0;
    load  = 1'b0;
    x     = '0;
    step();
    step();
    check("reset_y", 32'(y), 32'h00);
    check("reset_z", 32'(z), 32'h0);
    check("reset_empty", 32'(empty), 32'h1);
    rst_n = 1'b1;
    step();
    check("post_release_empty", 32'(empty), 32'h1);

    // All-ones word drains one bit per edge.
    exp_y = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    load = 1'b1; x = 8'hFF;
    step();
    load = 1'b0;
    check("ff_load_y", 32'(y), 32'hFF);
    check("ff_load_z", 32'(z), 32'h1);
    check("ff_load_empty", 32'(empty), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("ff_shift%0d_y", i + 1), 32'(y), 32'(exp_y[i]));
      check($sformatf("ff_shift%0d_z", i + 1), 32'(z), 32'(exp_y[i][0]));
      check($sformatf("ff_shift%0d_empty", i + 1), 32'(empty), (i == 7) ? 32'h1 : 32'h0);
    end

    // Asynchronous reset mid-cycle, loads ignored while held.
    load = 1'b1; x = 8'hFF;
    step();
    check("ar_pre_y", 32'(y), 32'hFF);
    #2;
    rst_n = 1'b0; x = 8'hAA;
    #1;
    check("ar_async_y", 32'(y), 32'h00);
    check("ar_async_z", 32'(z), 32'h0);
    check("ar_async_empty", 32'(empty), 32'h1);
    step();
    check("ar_held_y", 32'(y), 32'h00);
    check("ar_held_empty", 32'(empty), 32'h1);
    rst_n = 1'b1; load = 1'b0;
    step();
    check("ar_release_y", 32'(y), 32'h00);
    check("ar_release_empty", 32'(empty), 32'h1);

    // A5 pattern: z = 1,0,1,0,0,1,0,1.
    w = 8'b1010_0101;
    load = 1'b1; x = 8'hA5;
    step();
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("a5_bit%0d_z", k), 32'(z), 32'(w[k]));
      check($sformatf("a5_bit%0d_empty", k), 32'(empty), 32'h0);
      step();
    end
    check("a5_done_empty", 32'(empty), 32'h1);
    check("a5_done_z", 32'(z), 32'h0);

    // Reload before drain restarts the count.
    load = 1'b1; x = 8'hF0;
    step();
    load = 1'b0;
    step(); step(); step();
    check("rl_mid_y", 32'(y), 32'h1E);
    load = 1'b1; x = 8'h0F;
    step();
    load = 1'b0;
    check("rl_y", 32'(y), 32'h0F);
    check("rl_z", 32'(z), 32'h1);
    check("rl_empty", 32'(empty), 32'h0);
    for (int i = 0; i < 7; i++) step();
    check("rl_7_y", 32'(y), 32'h00);
    check("rl_7_empty", 32'(empty), 32'h0);
    step();
    check("rl_8_empty", 32'(empty), 32'h1);

    // Back-to-back words 3C then C3 with no gap on z.
    stream = 16'hC33C;
    load = 1'b1; x = 8'h3C;
    step();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("b2b_bit%0d_z", k), 32'(z), 32'(stream[k]));
      check($sformatf("b2b_bit%0d_empty", k), 32'(empty), 32'h0);
      if (k == 7) begin
        load = 1'b1; x = 8'hC3;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
    check("b2b_end_empty", 32'(empty), 32'h1);

    // Reset after 4 shifts, then shifting while empty.
    load = 1'b1; x = 8'hFF;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rm_pre_y", 32'(y), 32'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_async_y", 32'(y), 32'h00);
    check("rm_async_empty", 32'(empty), 32'h1);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rm_after_y", 32'(y), 32'h00);
    check("rm_after_z", 32'(z), 32'h0);
    check("rm_after_empty", 32'(empty), 32'h1);

    // Sustained load reloads every cycle and never shifts.
    load = 1'b1; x = 8'h81;
    step();
    step();
    check("sl_1_y", 32'(y), 32'h81);
    check("sl_1_empty", 32'(empty), 32'h0);
    step();
    check("sl_2_y", 32'(y), 32'h81);
    x = 8'h42;
    step();
    check("sl_3_y", 32'(y), 32'h42);
    check("sl_3_z", 32'(z), 32'h0);
    load = 1'b0;
    step();
    check("sl_shift_y", 32'(y), 32'h21);
    check("sl_shift_z", 32'(z), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_piso_shift_register
`default_nettype wire
